// File: rtl/vrased_reset_ctrl_if.sv
// Bundle between the VRASED monitor set / openMSP430 and the reset controller.
// master = monitor/CPU side, slave = vrased_reset_ctrl.
interface vrased_reset_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [5:0]       viol;
  logic [15:0]      pc;
  logic             clr_req;
  logic             cpu_rst;
  logic [5:0]       cause;
  logic [15:0]      viol_pc;
  logic [CNT_W-1:0] viol_cnt;
  logic             locked;

  modport master (
    output viol, pc, clr_req,
    input  cpu_rst, cause, viol_pc, viol_cnt, locked
  );

  modport slave (
    input  viol, pc, clr_req,
    output cpu_rst, cause, viol_pc, viol_cnt, locked
  );
endinterface

// File: rtl/vrased_reset_ctrl.sv
// Stretches VRASED monitor violations into a CPU reset and keeps cause/PC/count forensics.
// Optional permanent lockout after MAX_VIOL episodes when VRASED_LOCKOUT_EN is defined.
//
// state | meaning
// IDLE  | no violation pending; cpu_rst follows viol combinationally
// HOLD  | episode in progress; hold counter stretches cpu_rst after viol drops
// LOCK  | core locked out until reset (VRASED_LOCKOUT_EN only)
module vrased_reset_ctrl #(
  parameter int          HOLD_CYCLES   = 4,
  parameter int          CNT_W         = 8,
  parameter int          MAX_VIOL      = 3,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  vrased_reset_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || MAX_VIOL < 1) begin : g_bad_param
    $error("vrased_reset_ctrl: HOLD_CYCLES must be 1..255 and MAX_VIOL >= 1");
  end

  state_t           state, state_n;
  logic [5:0]       cause, cause_n;
  logic [15:0]      viol_pc, viol_pc_n;
  logic [CNT_W-1:0] viol_cnt, viol_cnt_n, cnt_inc;
  logic [7:0]       hold_cnt, hold_cnt_n;
  logic             any_viol;

  assign any_viol = |bus.viol;
  assign cnt_inc  = (viol_cnt == '1) ? viol_cnt : viol_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cause    <= '0;
      viol_pc  <= RESET_HANDLER;
      viol_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      cause    <= cause_n;
      viol_pc  <= viol_pc_n;
      viol_cnt <= viol_cnt_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cause_n    = cause;
    viol_pc_n  = viol_pc;
    viol_cnt_n = viol_cnt;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        // A violation in the same cycle as a clear request wins; the clear is lost.
        if (any_viol) begin
          cause_n    = cause | bus.viol;
          viol_pc_n  = bus.pc;
          viol_cnt_n = cnt_inc;
          hold_cnt_n = HOLD_RELOAD;
          state_n    = HOLD;
`ifdef VRASED_LOCKOUT_EN
          if (int'(cnt_inc) >= MAX_VIOL) state_n = LOCK;
`endif
        end else if (bus.clr_req) begin
          cause_n   = '0;
          viol_pc_n = RESET_HANDLER;
        end
      end
      HOLD: begin
        if (any_viol) begin
          cause_n    = cause | bus.viol;
          hold_cnt_n = HOLD_RELOAD;
        end else if (hold_cnt == 8'd0) begin
          state_n = IDLE;
        end else begin
          hold_cnt_n = hold_cnt - 8'd1;
        end
      end
`ifdef VRASED_LOCKOUT_EN
      LOCK: begin
        cause_n = cause | bus.viol;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Gated by reset so the core never sees a reset pulse from us while we are held in reset.
  assign bus.cpu_rst  = ~reset & (any_viol | (state != IDLE));
  assign bus.cause    = cause;
  assign bus.viol_pc  = viol_pc;
  assign bus.viol_cnt = viol_cnt;

`ifdef VRASED_LOCKOUT_EN
  assign bus.locked = (state == LOCK);
`else
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed self-checking bench for vrased_reset_ctrl (HOLD_CYCLES=4, CNT_W=8).
// Lockout scenario runs only when VRASED_LOCKOUT_EN is defined.
module tb_vrased_reset_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vrased_reset_ctrl_if #(.CNT_W(8)) bus ();

  vrased_reset_ctrl #(
    .HOLD_CYCLES  (4),
    .CNT_W        (8),
    .MAX_VIOL     (3),
    .RESET_HANDLER(16'h0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.viol = 6'h00; bus.pc = 16'h0000; bus.clr_req = 1'b0;
    #22;
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst got %b want 0", bus.cpu_rst); end
    checks++;
    if (bus.cause !== 6'h00) begin errors++; $display("FAIL reset_cause got %h want 00", bus.cause); end
    checks++;
    if (bus.viol_pc !== 16'h0000) begin errors++; $display("FAIL reset_viol_pc got %h want 0000", bus.viol_pc); end
    checks++;
    if (bus.viol_cnt !== 8'h00) begin errors++; $display("FAIL reset_viol_cnt got %h want 00", bus.viol_cnt); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", bus.locked); end
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pulse();
    tick();
    bus.viol = 6'b000010; bus.pc = 16'hA010;
    #1;
    checks++;
    if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL pulse_same_cycle got %b want 1", bus.cpu_rst); end
    tick();
    bus.viol = 6'h00; bus.pc = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL pulse_hold[%0d] got %b want 1", i, bus.cpu_rst); end
      tick();
    end
    #1;
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL pulse_release got %b want 0", bus.cpu_rst); end
    checks++;
    if (bus.cause !== 6'h02) begin errors++; $display("FAIL pulse_cause got %h want 02", bus.cause); end
    checks++;
    if (bus.viol_pc !== 16'hA010) begin errors++; $display("FAIL pulse_viol_pc got %h want a010", bus.viol_pc); end
    checks++;
    if (bus.viol_cnt !== 8'd1) begin errors++; $display("FAIL pulse_viol_cnt got %0d want 1", bus.viol_cnt); end
  endtask

  task automatic test_clear();
    // collision: clear and violation together from cause=02
    tick();
    bus.viol = 6'h04; bus.clr_req = 1'b1; bus.pc = 16'hA100;
    tick();
    bus.viol = 6'h00; bus.clr_req = 1'b0;
    #1;
    checks++;
    if (bus.cause !== 6'h06) begin errors++; $display("FAIL collision_cause got %h want 06", bus.cause); end
    checks++;
    if (bus.viol_pc !== 16'hA100) begin errors++; $display("FAIL collision_viol_pc got %h want a100", bus.viol_pc); end
    checks++;
    if (bus.viol_cnt !== 8'd2) begin errors++; $display("FAIL collision_viol_cnt got %0d want 2", bus.viol_cnt); end
    // clear inside HOLD must be ignored
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    tick(); tick(); tick();
    #1;
    checks++;
    if (bus.cause !== 6'h06) begin errors++; $display("FAIL hold_clear_ignored got %h want 06", bus.cause); end
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL collision_release got %b want 0", bus.cpu_rst); end
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    #1;
    checks++;
    if (bus.cause !== 6'h00) begin errors++; $display("FAIL clear_cause got %h want 00", bus.cause); end
    checks++;
    if (bus.viol_pc !== 16'h0000) begin errors++; $display("FAIL clear_viol_pc got %h want 0000", bus.viol_pc); end
    checks++;
    if (bus.viol_cnt !== 8'd2) begin errors++; $display("FAIL clear_keeps_cnt got %0d want 2", bus.viol_cnt); end
  endtask

  task automatic test_episode();
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.viol = (k == 3) ? 6'h20 : 6'h01;
      bus.pc   = 16'hB000 + 16'(k);
      #1;
      checks++;
      if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL episode_active[%0d] got %b want 1", k, bus.cpu_rst); end
      tick();
    end
    bus.viol = 6'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL episode_trail[%0d] got %b want 1", i, bus.cpu_rst); end
      tick();
    end
    #1;
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL episode_release got %b want 0", bus.cpu_rst); end
    checks++;
    if (bus.cause !== 6'h21) begin errors++; $display("FAIL episode_cause got %h want 21", bus.cause); end
    checks++;
    if (bus.viol_pc !== 16'hB000) begin errors++; $display("FAIL episode_viol_pc got %h want b000", bus.viol_pc); end
    checks++;
    if (bus.viol_cnt !== 8'd3) begin errors++; $display("FAIL episode_viol_cnt got %0d want 3", bus.viol_cnt); end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.viol = 6'h08; bus.pc = 16'hC000;
    tick();
    bus.viol = 6'h00;
    tick(); tick(); tick(); tick();
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.cpu_rst); end
    checks++;
    if (bus.viol_cnt !== 8'd4) begin errors++; $display("FAIL b2b_cnt_first got %0d want 4", bus.viol_cnt); end
    bus.viol = 6'h10; bus.pc = 16'hC100;
    tick();
    bus.viol = 6'h00;
    #1;
    checks++;
    if (bus.viol_pc !== 16'hC100) begin errors++; $display("FAIL b2b_viol_pc got %h want c100", bus.viol_pc); end
    checks++;
    if (bus.viol_cnt !== 8'd5) begin errors++; $display("FAIL b2b_cnt_second got %0d want 5", bus.viol_cnt); end
    checks++;
    if (bus.cause !== 6'h39) begin errors++; $display("FAIL b2b_cause got %h want 39", bus.cause); end
    tick(); tick(); tick(); tick();
    #1;
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", bus.cpu_rst); end
  endtask

  task automatic test_async_reset();
    tick();
    bus.viol = 6'h01; bus.pc = 16'hD000;
    tick();
    bus.viol = 6'h00;
    tick();
    // hold counter now 2, well clear of any edge
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL async_cpu_rst got %b want 0", bus.cpu_rst); end
    checks++;
    if (bus.cause !== 6'h00) begin errors++; $display("FAIL async_cause got %h want 00", bus.cause); end
    checks++;
    if (bus.viol_cnt !== 8'd0) begin errors++; $display("FAIL async_viol_cnt got %0d want 0", bus.viol_cnt); end
    checks++;
    if (bus.viol_pc !== 16'h0000) begin errors++; $display("FAIL async_viol_pc got %h want 0000", bus.viol_pc); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL async_locked got %b want 0", bus.locked); end
    #2 reset = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL async_post_release got %b want 0", bus.cpu_rst); end
  endtask

  task automatic test_saturation();
    for (int e = 1; e <= 300; e++) begin
      tick();
      bus.viol = 6'h01;
      tick();
      bus.viol = 6'h00;
      tick(); tick(); tick(); tick();
      if (e == 254) begin
        checks++;
        if (bus.viol_cnt !== 8'hFE) begin errors++; $display("FAIL sat_cnt_254 got %h want fe", bus.viol_cnt); end
      end
      if (e == 255) begin
        checks++;
        if (bus.viol_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cnt_255 got %h want ff", bus.viol_cnt); end
      end
    end
    #1;
    checks++;
    if (bus.viol_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cnt_300 got %h want ff", bus.viol_cnt); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL sat_locked got %b want 0", bus.locked); end
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL sat_release got %b want 0", bus.cpu_rst); end
  endtask

  task automatic test_lockout();
    for (int e = 1; e <= 3; e++) begin
      tick();
      bus.viol = 6'h01;
      tick();
      bus.viol = 6'h00;
      #1;
      if (e == 2) begin
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", bus.locked); end
      end
      if (e < 3) begin
        tick(); tick(); tick(); tick();
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_engaged got %b want 1", bus.locked); end
    for (int i = 0; i < 110; i++) begin
      bus.clr_req = (i % 10 == 5);
      bus.viol    = (i == 50) ? 6'h04 : 6'h00;
      tick();
      checks++;
      if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL lock_cpu_rst[%0d] got %b want 1", i, bus.cpu_rst); end
    end
    bus.clr_req = 1'b0;
    checks++;
    if (bus.cause !== 6'h05) begin errors++; $display("FAIL lock_cause got %h want 05", bus.cause); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_reset got %b want 0", bus.locked); end
    #2 reset = 1'b0;
    tick();
    checks++;
    if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL lock_released got %b want 0", bus.cpu_rst); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifdef VRASED_LOCKOUT_EN
    test_lockout();
`else
    test_single_pulse();
    test_clear();
    test_episode();
    test_back_to_back();
    test_async_reset();
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
